// File: rtl/layer_argmax_if.sv
// Handshake/bus bundle for the argmax classification stage.
//   in_valid  : layer input strobe (master -> slave)
//   node_vec  : packed node outputs, element i at [i*DATA_W +: DATA_W] (master -> slave)
//   busy      : scan in progress (slave -> master)
//   out_valid : one-cycle result strobe (slave -> master)
//   class_idx : index of the maximum element (slave -> master)
//   class_val : value of the maximum element, signed (slave -> master)
//   overrun   : sticky dropped-vector flag (slave -> master)
interface layer_argmax_if #(
  parameter int NUM_IN = 5,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) ();
  logic                       in_valid;
  logic [NUM_IN*DATA_W-1:0]   node_vec;
  logic                       busy;
  logic                       out_valid;
  logic [IDX_W-1:0]           class_idx;
  logic [DATA_W-1:0]          class_val;
  logic                       overrun;

  modport master (
    output in_valid, node_vec,
    input  busy, out_valid, class_idx, class_val, overrun
  );

  modport slave (
    input  in_valid, node_vec,
    output busy, out_valid, class_idx, class_val, overrun
  );
endinterface

// File: rtl/layer_argmax.sv
// layer_argmax: final classification stage behind the last dense layer.
// A LAYER_LAT-deep delay line aligns in_valid with the node outputs; the aligned
// strobe captures node_vec, which is then scanned one element per cycle with a
// single signed comparator. The winning index/value is presented with a
// one-cycle out_valid strobe and held until the next result.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : layer_argmax_if slave modport (in_valid, node_vec in;
//           busy, out_valid, class_idx, class_val, overrun out)
module layer_argmax #(
  parameter int NUM_IN    = 5,
  parameter int DATA_W    = 16,
  parameter int LAYER_LAT = 3,
  parameter int IDX_W     = 4
) (
  input  logic           clk,
  input  logic           reset,
  layer_argmax_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [LAYER_LAT-1:0]       dl_q, dl_d;
  logic [NUM_IN*DATA_W-1:0]   vec_q, vec_d;
  logic signed [DATA_W-1:0]   best_val_q, best_val_d;
  logic [IDX_W-1:0]           best_idx_q, best_idx_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic                       out_valid_q, out_valid_d;
  logic [IDX_W-1:0]           class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0]   class_val_q, class_val_d;
  logic                       overrun_q, overrun_d;

  logic                       cap_valid;
  logic signed [DATA_W-1:0]   elem;
  logic                       take;

  assign cap_valid = dl_q[LAYER_LAT-1];

  // Element under scan; constant-index mux keeps the select width-clean.
  always_comb begin
    elem = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cnt_q == IDX_W'(i)) elem = vec_q[i*DATA_W +: DATA_W];
    end
  end

  // Strict greater-than so that ties keep the lower index.
  assign take = (elem > best_val_q);

  always_comb begin
    state_d     = state_q;
    dl_d        = dl_q << 1;
    dl_d[0]     = bus.in_valid;
    vec_d       = vec_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    class_idx_d = class_idx_q;
    class_val_d = class_val_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (cap_valid) begin
          vec_d      = bus.node_vec;
          best_val_d = bus.node_vec[DATA_W-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          state_d    = SCAN;
        end else begin
          state_d    = IDLE;
        end
      end
      SCAN: begin
        if (cap_valid) overrun_d = 1'b1;
        if (take) begin
          best_val_d = elem;
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_IN-1)) begin
          // Last compare folds straight into the registered result.
          state_d     = DONE;
          out_valid_d = 1'b1;
          class_idx_d = take ? cnt_q : best_idx_q;
          class_val_d = take ? elem  : best_val_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_q        <= '0;
      vec_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      class_val_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      vec_q       <= vec_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      class_idx_q <= class_idx_d;
      class_val_q <= class_val_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.class_idx = class_idx_q;
  assign bus.class_val = class_val_q;
  assign bus.overrun   = overrun_q;

endmodule
